// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 character-LCD controllers.
// Contains the read-controller state type, the LCD data-bus constants and
// the ns-to-clock-cycle rounding helper used by both the read and write sides.
package lcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD
  } lcd_rd_state_e;

  localparam int LCD_BUSY_BIT = 7;
  localparam int LCD_DATA_W   = 8;

  // Round a time up to a whole number of clock periods.
  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter that times each phase of an LCD bus cycle.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load         : load i_load_val this cycle (takes priority over counting)
//   i_load_val     : phase length minus one
//   o_done         : high in the last cycle of the loaded phase (count == 0)
module lcd_phase_timer #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (i_load) begin
      cnt <= i_load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign o_done = (cnt == '0);

endmodule

// File: rtl/lcd_rd_ctrl.sv
// HD44780 read-cycle controller (RW=1): busy-flag/AC reads (RS=0) and
// DDRAM/CGRAM data reads (RS=1), with optional busy-flag polling.
// Ports:
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_vld / o_rdy    : request handshake; o_rdy is high only while idle
//   i_rs, i_poll     : request register select; poll honoured only for RS=0
//   o_rd_vld         : one-cycle response strobe
//   o_rd_data        : last sampled DB[7:0], held until the next sample
//   o_timeout        : with o_rd_vld, poll gave up with the busy flag still set
//   o_LCD_RW/RS/EN   : LCD control pins (muxed with the write controller)
//   o_LCD_OE_N       : low while active; releases DQ driver / selects this block
//   i_LCD_DATA       : DB[7:0] from the top-level tristate
module lcd_rd_ctrl
  import lcd_pkg::*;
#(
  parameter int T_PERIOD_NS = 40,
  parameter int T_AS_NS     = 80,
  parameter int T_PW_NS     = 460,
  parameter int T_DDR_NS    = 320,
  parameter int T_CYCE_NS   = 1000,
  parameter int POLL_MAX    = 4000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_vld,
  output logic                  o_rdy,
  input  logic                  i_rs,
  input  logic                  i_poll,
  output logic                  o_rd_vld,
  output logic [LCD_DATA_W-1:0] o_rd_data,
  output logic                  o_timeout,
  output logic                  o_LCD_RW,
  output logic                  o_LCD_RS,
  output logic                  o_LCD_EN,
  output logic                  o_LCD_OE_N,
  input  logic [LCD_DATA_W-1:0] i_LCD_DATA
);

  localparam int N_AS   = ceil_div(T_AS_NS, T_PERIOD_NS);
  localparam int N_PW   = ceil_div(T_PW_NS, T_PERIOD_NS);
  localparam int N_CYC  = ceil_div(T_CYCE_NS, T_PERIOD_NS);
  localparam int N_HOLD = N_CYC - N_AS - N_PW;
  localparam int N_MAX  = (N_AS > N_PW) ? ((N_AS > N_HOLD) ? N_AS : N_HOLD)
                                        : ((N_PW > N_HOLD) ? N_PW : N_HOLD);
  localparam int TMR_W  = $clog2(N_MAX + 1);
  localparam int PCNT_W = $clog2(POLL_MAX + 1);

  if (T_DDR_NS >= T_PW_NS) begin : g_bad_ddr
    $error("lcd_rd_ctrl: T_DDR_NS must be less than T_PW_NS");
  end
  if (N_AS < 1) begin : g_bad_as
    $error("lcd_rd_ctrl: setup phase must be at least one cycle");
  end
  if (N_HOLD < 1) begin : g_bad_hold
    $error("lcd_rd_ctrl: hold phase must be at least one cycle");
  end

  lcd_rd_state_e     state, state_d;
  logic              rs_q, rs_d;
  logic              poll_q, poll_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_val;
  logic              tmr_done;
  logic              sample;
  logic              finish;

  logic rdy_d, rd_vld_d, timeout_d, rw_d, rs_pin_d, en_d, oe_n_d;

  lcd_phase_timer #(.W(TMR_W)) u_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (tmr_load),
    .i_load_val (tmr_val),
    .o_done     (tmr_done)
  );

  // State register; the pins are registered from the next-state decode so
  // they change exactly on phase boundaries and clear asynchronously on reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      rs_q       <= 1'b0;
      poll_q     <= 1'b0;
      pcnt_q     <= '0;
      o_rdy      <= 1'b1;
      o_rd_vld   <= 1'b0;
      o_rd_data  <= '0;
      o_timeout  <= 1'b0;
      o_LCD_RW   <= 1'b0;
      o_LCD_RS   <= 1'b0;
      o_LCD_EN   <= 1'b0;
      o_LCD_OE_N <= 1'b1;
    end else begin
      state      <= state_d;
      rs_q       <= rs_d;
      poll_q     <= poll_d;
      pcnt_q     <= pcnt_d;
      o_rdy      <= rdy_d;
      o_rd_vld   <= rd_vld_d;
      o_timeout  <= timeout_d;
      o_LCD_RW   <= rw_d;
      o_LCD_RS   <= rs_pin_d;
      o_LCD_EN   <= en_d;
      o_LCD_OE_N <= oe_n_d;
      if (sample) begin
        o_rd_data <= i_LCD_DATA;
      end
    end
  end

  // Next-state logic; the phase timer is reloaded on every state entry.
  always_comb begin
    state_d  = state;
    rs_d     = rs_q;
    poll_d   = poll_q;
    pcnt_d   = pcnt_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    sample   = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE: begin
        if (i_vld) begin
          state_d  = SETUP;
          rs_d     = i_rs;
          poll_d   = i_poll & ~i_rs;
          pcnt_d   = '0;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(N_AS - 1);
        end
      end
      SETUP: begin
        if (tmr_done) begin
          state_d  = PULSE;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(N_PW - 1);
        end
      end
      PULSE: begin
        if (tmr_done) begin
          sample   = 1'b1;
          state_d  = HOLD;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(N_HOLD - 1);
        end
      end
      HOLD: begin
        if (tmr_done) begin
          // o_rd_data already holds this read's DB7 (sampled at end of PULSE).
          if (poll_q && o_rd_data[LCD_BUSY_BIT] &&
              (pcnt_q < PCNT_W'(POLL_MAX - 1))) begin
            pcnt_d   = pcnt_q + 1'b1;
            state_d  = SETUP;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(N_AS - 1);
          end else begin
            state_d = IDLE;
            finish  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode of the upcoming state, registered above.
  always_comb begin
    rdy_d     = (state_d == IDLE);
    rw_d      = (state_d != IDLE);
    rs_pin_d  = (state_d != IDLE) & rs_d;
    en_d      = (state_d == PULSE);
    oe_n_d    = (state_d == IDLE);
    rd_vld_d  = finish;
    timeout_d = finish & poll_q & o_rd_data[LCD_BUSY_BIT];
  end

endmodule

// File: tb/tb_lcd_rd_ctrl.sv
module tb_lcd_rd_ctrl;

  localparam int N_AS  = 2;
  localparam int N_PW  = 12;
  localparam int N_CYC = 25;
  localparam int PMAX0 = 4000;
  localparam int PMAX1 = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] vld   = '0;
  logic       rs    = 1'b0;
  logic       poll  = 1'b0;
  logic [7:0] db    = '0;

  logic       rdy [2];
  logic       rd_vld [2];
  logic       tmo [2];
  logic       rw [2];
  logic       rs_o [2];
  logic       en [2];
  logic       oe_n [2];
  logic [7:0] rd_data [2];

  int nchk = 0;
  int nfail = 0;
  int cyc = 0;

  lcd_rd_ctrl dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_vld(vld[0]), .o_rdy(rdy[0]),
    .i_rs(rs), .i_poll(poll), .o_rd_vld(rd_vld[0]), .o_rd_data(rd_data[0]),
    .o_timeout(tmo[0]), .o_LCD_RW(rw[0]), .o_LCD_RS(rs_o[0]), .o_LCD_EN(en[0]),
    .o_LCD_OE_N(oe_n[0]), .i_LCD_DATA(db)
  );

  lcd_rd_ctrl #(.POLL_MAX(PMAX1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_vld(vld[1]), .o_rdy(rdy[1]),
    .i_rs(rs), .i_poll(poll), .o_rd_vld(rd_vld[1]), .o_rd_data(rd_data[1]),
    .o_timeout(tmo[1]), .o_LCD_RW(rw[1]), .o_LCD_RS(rs_o[1]), .o_LCD_EN(en[1]),
    .o_LCD_OE_N(oe_n[1]), .i_LCD_DATA(db)
  );

  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pmax(input int i);
    return (i == 0) ? PMAX0 : PMAX1;
  endfunction

  // Behavioural model: a transaction is a sequence of N_CYC-cycle reads counted
  // from the cycle after the handshake; each read has EN high for cycle offsets
  // N_AS..N_AS+N_PW-1 and samples DB at the last high cycle.
  bit         m_busy [2];
  int         m_c [2];
  bit         m_rs [2];
  bit         m_poll [2];
  bit         m_vld [2];
  bit         m_to [2];
  logic [7:0] m_data [2];

  always @(posedge clk or negedge rst_n) begin
    int off;
    int k;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_busy[i] = 1'b0; m_c[i] = 0; m_rs[i] = 1'b0; m_poll[i] = 1'b0;
        m_vld[i] = 1'b0; m_to[i] = 1'b0; m_data[i] = 8'h00;
      end else begin
        m_vld[i] = 1'b0;
        m_to[i]  = 1'b0;
        if (!m_busy[i]) begin
          if (vld[i]) begin
            m_busy[i] = 1'b1; m_c[i] = 1; m_rs[i] = rs; m_poll[i] = poll && !rs;
          end
        end else begin
          off = (m_c[i] - 1) % N_CYC;
          k   = (m_c[i] - 1) / N_CYC + 1;
          if (off == N_AS + N_PW - 1) m_data[i] = db;
          if (off == N_CYC - 1 && !(m_poll[i] && m_data[i][7] && k < pmax(i))) begin
            m_busy[i] = 1'b0;
            m_vld[i]  = 1'b1;
            m_to[i]   = m_poll[i] && m_data[i][7];
          end else begin
            m_c[i]++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    int  off;
    bit  e_en;
    for (int i = 0; i < 2; i++) begin
      off  = (m_c[i] - 1) % N_CYC;
      e_en = m_busy[i] && off >= N_AS && off < N_AS + N_PW;
      chk($sformatf("rdy%0d", i),     rdy[i],     !m_busy[i]);
      chk($sformatf("rw%0d", i),      rw[i],      m_busy[i]);
      chk($sformatf("oe_n%0d", i),    oe_n[i],    !m_busy[i]);
      chk($sformatf("rs%0d", i),      rs_o[i],    m_busy[i] && m_rs[i]);
      chk($sformatf("en%0d", i),      en[i],      e_en);
      chk($sformatf("rd_vld%0d", i),  rd_vld[i],  m_vld[i]);
      chk($sformatf("timeout%0d", i), tmo[i],     m_to[i]);
      chk($sformatf("rd_data%0d", i), rd_data[i], m_data[i]);
    end
  end

  task automatic do_req(input int idx, input logic r, input logic p, output int t);
    rs = r;
    poll = p;
    vld[idx] = 1'b1;
    t = cyc;
    @(posedge clk);
    #2;
    vld[idx] = 1'b0;
  endtask

  task automatic watch(input int idx, input int budget, output int vcyc, output int rises,
                       output int first, output int hi, output int bad,
                       output logic [7:0] d, output logic to);
    logic pe;
    pe = 1'b0; vcyc = -1; rises = 0; first = -1; hi = 0; bad = 0; d = '0; to = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (rd_vld[idx]) begin
        vcyc = cyc; d = rd_data[idx]; to = tmo[idx];
        break;
      end
      if (en[idx]) hi++;
      if (en[idx] && !pe) begin
        rises++;
        if (first < 0) first = cyc;
      end
      pe = en[idx];
      if (rw[idx] !== 1'b1 || oe_n[idx] !== 1'b0) bad++;
    end
    if (vcyc < 0) chk("rd_vld_wait", 32'd0, 32'd1);
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (rdy[0] && rdy[1]) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_wait", ok, 1'b1);
    @(posedge clk);
    #2;
  endtask

  initial begin
    int t, vc, ri, fi, hi, bd, nv;
    logic [7:0] d;
    logic to, pe;
    int rise[$];
    int vq[$];

    repeat (2) @(posedge clk);
    #2;
    chk("rst_rdy", rdy[0], 1'b1);
    chk("rst_vld", rd_vld[0], 1'b0);
    chk("rst_data", rd_data[0], 8'h00);
    chk("rst_en", en[0], 1'b0);
    chk("rst_oe_n", oe_n[0], 1'b1);
    chk("rst_rw", rw[0], 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    // Data read, RS=1
    db = 8'h41;
    do_req(0, 1'b1, 1'b0, t);
    watch(0, 60, vc, ri, fi, hi, bd, d, to);
    chk("s1_vld_cyc", vc, t + 26);
    chk("s1_data", d, 8'h41);
    chk("s1_en_hi", hi, 12);
    chk("s1_en_first", fi, t + 3);
    chk("s1_rw_oe", bd, 0);
    chk("s1_timeout", to, 1'b0);

    // Poll: three busy reads, then busy clear with AC=5
    db = 8'h80 | 8'($urandom_range(0, 127));
    do_req(0, 1'b0, 1'b1, t);
    fork
      watch(0, 200, vc, ri, fi, hi, bd, d, to);
      begin
        repeat (75) @(posedge clk);
        #2;
        db = 8'h05;
      end
    join
    chk("s2_vld_cyc", vc, t + 101);
    chk("s2_data", d, 8'h05);
    chk("s2_timeout", to, 1'b0);
    chk("s2_pulses", ri, 4);

    // Poll limit on the POLL_MAX=4 instance
    db = 8'hC3;
    do_req(1, 1'b0, 1'b1, t);
    watch(1, 200, vc, ri, fi, hi, bd, d, to);
    chk("s3_vld_cyc", vc, t + 101);
    chk("s3_timeout", to, 1'b1);
    chk("s3_db7", d[7], 1'b1);
    chk("s3_pulses", ri, 4);

    // Busy read without poll
    db = 8'h80;
    do_req(0, 1'b0, 1'b0, t);
    watch(0, 60, vc, ri, fi, hi, bd, d, to);
    chk("s4_vld_cyc", vc, t + 26);
    chk("s4_data", d, 8'h80);
    chk("s4_timeout", to, 1'b0);
    chk("s4_pulses", ri, 1);

    // i_vld held high: re-accept in the response cycle
    rs = 1'b1; poll = 1'b0; db = 8'h3C;
    vld[0] = 1'b1;
    t = cyc;
    pe = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (en[0] && !pe) rise.push_back(cyc);
      pe = en[0];
      if (rd_vld[0]) vq.push_back(cyc);
    end
    @(posedge clk);
    #2;
    vld[0] = 1'b0;
    chk("s5_nrise", rise.size(), 3);
    if (rise.size() >= 2) chk("s5_period", rise[1] - rise[0], 26);
    chk("s5_vld0", (vq.size() > 0) ? vq[0] : -1, t + 26);
    chk("s5_rehs", (rise.size() > 1) ? rise[1] : -1, t + 29);
    wait_idle(100);

    // Reset in the middle of PULSE
    db = 8'h5A;
    do_req(0, 1'b1, 1'b0, t);
    repeat (7) @(posedge clk);
    #2;
    chk("s6_en_pre", en[0], 1'b1);
    rst_n = 1'b0;
    #1;
    chk("s6_en_async", en[0], 1'b0);
    chk("s6_oe_async", oe_n[0], 1'b1);
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    nv = 0;
    repeat (40) begin
      @(negedge clk);
      if (rd_vld[0]) nv++;
    end
    chk("s6_no_vld", nv, 0);
    chk("s6_rdy", rdy[0], 1'b1);
    chk("s6_oe_n", oe_n[0], 1'b1);
    @(posedge clk);
    #2;
    db = 8'hA7;
    do_req(0, 1'b1, 1'b0, t);
    watch(0, 60, vc, ri, fi, hi, bd, d, to);
    chk("s6_vld_cyc", vc, t + 26);
    chk("s6_data", d, 8'hA7);

    // Randomized traffic on both instances, checked by the model every cycle
    repeat (400) begin
      vld[0] = ($urandom_range(0, 3) == 0);
      vld[1] = ($urandom_range(0, 3) == 0);
      rs     = 1'($urandom_range(0, 1));
      poll   = 1'($urandom_range(0, 1));
      db     = 8'($urandom);
      @(posedge clk);
      #2;
    end
    vld = '0;
    wait_idle(3000);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
